lcd_nibble_writer: RTL and testbench

LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

---
 rtl/lcd_nibble_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit write-only LCD driver: runs the power-up/init nibble sequence, then
// splits each accepted byte into two enable-strobed nibbles followed by a settle wait.
module lcd_nibble_writer #(
  parameter int SETUP_CYC     = 8,
  parameter int E_HIGH_CYC    = 48,
  parameter int HOLD_CYC      = 2,
  parameter int GAP_CYC       = 200,
  parameter int CMD_WAIT_CYC  = 8000,
  parameter int LONG_WAIT_CYC = 328000,
  parameter int PWRUP_CYC     = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  output logic       in_ready,
  output logic       init_done,
  output logic [3:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  localparam int CW    = 32;
  localparam int E_EFF = (E_HIGH_CYC < 1) ? 1 : E_HIGH_CYC;

  localparam logic [CW-1:0] SETUP_N = CW'(SETUP_CYC);
  localparam logic [CW-1:0] EHI_N   = CW'(E_EFF);
  localparam logic [CW-1:0] HOLD_N  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] GAP_N   = CW'(GAP_CYC);
  localparam logic [CW-1:0] CMD_N   = CW'(CMD_WAIT_CYC);
  localparam logic [CW-1:0] LONG_N  = CW'(LONG_WAIT_CYC);
  localparam logic [CW-1:0] PWRUP_N = CW'(PWRUP_CYC);

  // INIT_NIB is the long settle wait that follows each init nibble.
  typedef enum logic [2:0] {PWRUP, INIT_NIB, IDLE, SETUP, E_HI, HOLD, GAP, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_rs_q, byte_rs_d;
  logic          low_q, low_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          e_q;
  logic          init_done_q, init_done_d;

  logic          go_hold, go_after_hold, go_gap, go_init_wait, go_next_init;
  logic          go_wait, go_setup, go_ehi;
  logic          long_cmd;
  logic [CW-1:0] wait_len;

  assign in_ready  = (state_q == IDLE) && init_done_q;
  assign init_done = init_done_q;
  assign lcd_data  = data_q;
  assign lcd_e     = e_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;

  assign long_cmd = !byte_rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02) || (byte_q == 8'h03));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PWRUP;
      cnt_q       <= PWRUP_N;
      byte_q      <= 8'h00;
      byte_rs_q   <= 1'b0;
      low_q       <= 1'b0;
      idx_q       <= 2'd0;
      data_q      <= 4'h0;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      byte_rs_q   <= byte_rs_d;
      low_q       <= low_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      e_q         <= (state_d == E_HI);
      init_done_q <= init_done_d;
    end
  end

  // Phase exits raise go_* requests; the cascade below resolves them in dependency order so a
  // zero-length phase falls straight through to its successor within the same cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    byte_d        = byte_q;
    byte_rs_d     = byte_rs_q;
    low_d         = low_q;
    idx_d         = idx_q;
    data_d        = data_q;
    rs_d          = rs_q;
    init_done_d   = init_done_q;
    go_hold       = 1'b0;
    go_after_hold = 1'b0;
    go_gap        = 1'b0;
    go_init_wait  = 1'b0;
    go_next_init  = 1'b0;
    go_wait       = 1'b0;
    go_setup      = 1'b0;
    go_ehi        = 1'b0;
    wait_len      = long_cmd ? LONG_N : CMD_N;

    case (state_q)
      PWRUP: begin
        if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
        else begin
          idx_d    = 2'd0;
          data_d   = 4'h3;
          rs_d     = 1'b0;
          go_setup = 1'b1;
        end
      end
      IDLE: begin
        if (in_valid && init_done_q) begin
          byte_d    = in_data;
          byte_rs_d = in_rs;
          low_d     = 1'b0;
          data_d    = in_data[7:4];
          rs_d      = in_rs;
          go_setup  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
        else go_ehi = 1'b1;
      end
      E_HI: begin
        if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
        else go_hold = 1'b1;
      end
      HOLD: begin
        if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
        else go_after_hold = 1'b1;
      end
      GAP: begin
        if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
        else begin
          low_d    = 1'b1;
          data_d   = byte_q[3:0];
          go_setup = 1'b1;
        end
      end
      INIT_NIB: begin
        if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
        else go_next_init = 1'b1;
      end
      WAIT: begin
        if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
        else state_d = IDLE;
      end
      default: state_d = PWRUP;
    endcase

    if (go_hold) begin
      if (HOLD_N != '0) begin
        state_d = HOLD;
        cnt_d   = HOLD_N;
      end else go_after_hold = 1'b1;
    end

    if (go_after_hold) begin
      if (!init_done_q) go_init_wait = 1'b1;
      else if (low_q)   go_wait = 1'b1;
      else              go_gap = 1'b1;
    end

    if (go_gap) begin
      if (GAP_N != '0) begin
        state_d = GAP;
        cnt_d   = GAP_N;
      end else begin
        low_d    = 1'b1;
        data_d   = byte_q[3:0];
        go_setup = 1'b1;
      end
    end

    if (go_init_wait) begin
      if (LONG_N != '0) begin
        state_d = INIT_NIB;
        cnt_d   = LONG_N;
      end else go_next_init = 1'b1;
    end

    // Init nibbles are 3,3,3 then 2 (the switch into 4-bit mode).
    if (go_next_init) begin
      if (idx_q == 2'd3) begin
        state_d     = IDLE;
        init_done_d = 1'b1;
      end else begin
        idx_d    = idx_q + 2'd1;
        data_d   = (idx_q == 2'd2) ? 4'h2 : 4'h3;
        go_setup = 1'b1;
      end
    end

    if (go_wait) begin
      if (wait_len != '0) begin
        state_d = WAIT;
        cnt_d   = wait_len;
      end else state_d = IDLE;
    end

    if (go_setup) begin
      if (SETUP_N != '0) begin
        state_d = SETUP;
        cnt_d   = SETUP_N;
      end else go_ehi = 1'b1;
    end

    if (go_ehi) begin
      state_d = E_HI;
      cnt_d   = EHI_N;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Scoreboard bench for lcd_nibble_writer: stimulus queues expected nibbles, a negedge monitor
// pops one per lcd_e pulse and checks bus contents, pulse width and low spacing.
module tb_lcd_nibble_writer;

  localparam int S    = 2;
  localparam int E    = 4;
  localparam int H    = 1;
  localparam int G    = 3;
  localparam int CMD  = 10;
  localparam int LONG = 20;
  localparam int P    = 50;
  localparam int NIB  = S + E + H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_rs = 1'b0;
  logic       in_ready, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_data;

  typedef struct {
    logic [3:0] data;
    logic       rs;
    int         gap;
  } nib_t;

  nib_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  lcd_nibble_writer #(
    .SETUP_CYC(S), .E_HIGH_CYC(E), .HOLD_CYC(H), .GAP_CYC(G),
    .CMD_WAIT_CYC(CMD), .LONG_WAIT_CYC(LONG), .PWRUP_CYC(P)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_rs(in_rs),
    .in_ready(in_ready), .init_done(init_done), .lcd_data(lcd_data),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat(input int w);
    return 2 * NIB + G + w + 1;
  endfunction

  task automatic push_init();
    exp_q.push_back('{data: 4'h3, rs: 1'b0, gap: -1});
    exp_q.push_back('{data: 4'h3, rs: 1'b0, gap: H + LONG + S});
    exp_q.push_back('{data: 4'h3, rs: 1'b0, gap: H + LONG + S});
    exp_q.push_back('{data: 4'h2, rs: 1'b0, gap: H + LONG + S});
  endtask

  task automatic push_byte(input logic [7:0] d, input logic rs);
    exp_q.push_back('{data: d[7:4], rs: rs, gap: -1});
    exp_q.push_back('{data: d[3:0], rs: rs, gap: H + G + S});
  endtask

  task automatic check_reset_outputs();
    check_output("rst_lcd_e", lcd_e, 0);
    check_output("rst_lcd_data", lcd_data, 0);
    check_output("rst_lcd_rs", lcd_rs, 0);
    check_output("rst_lcd_rw", lcd_rw, 0);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_init_done", init_done, 0);
  endtask

  // Called at a negedge just after reset release; in_valid is held high to prove nothing is
  // accepted before init_done.
  task automatic await_init();
    int n = 0;
    int early = 0;
    in_valid = 1'b1;
    in_data  = 8'h41;
    in_rs    = 1'b1;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
      if (in_ready && !init_done) early++;
    end
    in_valid = 1'b0;
    check_output("init_cycles", n, P + 4 * (NIB + LONG));
    check_output("ready_before_init", early, 0);
    check_output("ready_after_init", in_ready, 1);
  endtask

  // Sends one byte at a negedge and measures cycles until in_ready returns; with scramble set,
  // in_valid stays high and the inputs churn for the whole transfer.
  task automatic apply_stimulus(input logic [7:0] d, input logic rs, input int exp_lat,
                                input bit scramble);
    int n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_rs    = rs;
    push_byte(d, rs);
    @(negedge clk);
    check_output("ready_drop", in_ready, 0);
    n = 1;
    if (!scramble) begin
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_rs    = 1'b0;
    end
    while (!in_ready && n < 2000) begin
      if (scramble) begin
        in_data = 8'($urandom);
        in_rs   = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check_output("latency", n, exp_lat);
  endtask

  initial begin : monitor
    logic prev_e;
    int   hi_cnt;
    int   low_cnt;
    logic have_cur;
    nib_t cur;
    prev_e = 1'b0;
    hi_cnt = 0;
    low_cnt = 0;
    have_cur = 1'b0;
    cur = '{data: 4'h0, rs: 1'b0, gap: -1};
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_e   = 1'b0;
        hi_cnt   = 0;
        low_cnt  = 0;
        have_cur = 1'b0;
      end else begin
        if (lcd_e && !prev_e) begin
          hi_cnt = 1;
          check_output("pulse_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            check_output("nib_data", lcd_data, cur.data);
            check_output("nib_rs", lcd_rs, cur.rs);
            if (cur.gap >= 0) check_output("e_low_gap", low_cnt, cur.gap);
          end else have_cur = 1'b0;
        end else if (lcd_e) begin
          hi_cnt++;
        end else if (prev_e) begin
          check_output("e_high_len", hi_cnt, E);
          if (have_cur) begin
            check_output("hold_data", lcd_data, cur.data);
            check_output("hold_rs", lcd_rs, cur.rs);
          end
          low_cnt = 1;
        end else begin
          low_cnt++;
        end
        prev_e = lcd_e;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int rises;
    int n;
    logic prev;
    #1 rst = 1'b0;
    #2 check_reset_outputs();

    push_init();
    @(negedge clk);
    rst = 1'b1;
    await_init();

    apply_stimulus(8'h41, 1'b1, lat(CMD), 1'b0);
    apply_stimulus(8'h01, 1'b0, lat(LONG), 1'b0);
    apply_stimulus(8'h28, 1'b0, lat(CMD), 1'b0);
    apply_stimulus(8'h03, 1'b1, lat(CMD), 1'b0);
    apply_stimulus(8'h02, 1'b0, lat(LONG), 1'b0);
    apply_stimulus(8'h04, 1'b0, lat(CMD), 1'b0);
    apply_stimulus(8'h03, 1'b0, lat(LONG), 1'b0);
    apply_stimulus(8'hA7, 1'b1, lat(CMD), 1'b1);
    apply_stimulus(8'h5C, 1'b1, lat(CMD), 1'b1);
    apply_stimulus(8'h3E, 1'b0, lat(CMD), 1'b0);

    // Reset in the middle of the low-nibble enable pulse of a data byte.
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_rs    = 1'b1;
    push_byte(8'h55, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rises = 0;
    n = 0;
    prev = lcd_e;
    while (rises < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (lcd_e && !prev) rises++;
      prev = lcd_e;
    end
    check_output("second_pulse_seen", rises, 2);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    check_output("queue_after_reset", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs();

    push_init();
    rst = 1'b1;
    await_init();
    apply_stimulus(8'h02, 1'b0, lat(LONG), 1'b0);

    repeat (5) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
